// File: rtl/reg_write_port.sv
// Register-file write port: small request FIFO drained one entry per cycle into a one-hot wordline.
// Optional pending-write bypass lookup is enabled by defining REG_WRITE_PORT_BYPASS_EN.
module reg_write_port #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_regid,
    input  logic [DW-1:0]          in_data,
    input  logic                   wr_stall,
    output logic                   WriteEnable,
    output logic [15:0]            WriteWordline,
    output logic [DW-1:0]          WriteData,
    output logic [$clog2(DEPTH):0] pending,
    input  logic [3:0]             byp_regid,
    output logic                   byp_hit,
    output logic [DW-1:0]          byp_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    regid_mem [DEPTH];
    logic [DW-1:0] data_mem  [DEPTH];

    logic [AW-1:0] wptr_reg, wptr_next;
    logic [AW-1:0] rptr_reg, rptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic          push;
    logic          pop;
    logic          head_valid;
    logic [3:0]    head_regid;
    logic [DW-1:0] head_data;

    // Ready is derived from the registered count only, so no input reaches it combinationally.
    assign in_ready   = (count_reg != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign head_valid = (count_reg != '0);
    assign pop        = head_valid && !wr_stall;
    assign head_regid = regid_mem[rptr_reg];
    assign head_data  = data_mem[rptr_reg];
    assign pending    = count_reg;

    always_comb begin
        wptr_next  = push ? wptr_reg + 1'b1 : wptr_reg;
        rptr_next  = pop  ? rptr_reg + 1'b1 : rptr_reg;
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: every consumer qualifies entries by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            regid_mem[wptr_reg] <= in_regid;
            data_mem[wptr_reg]  <= in_data;
        end
    end

    // R0 requests still consume a drain slot but never strobe the register file.
    assign WriteEnable = pop && (head_regid != 4'd0);
    assign WriteData   = WriteEnable ? head_data : '0;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_wordline
            assign WriteWordline[gi] = WriteEnable && (head_regid == 4'(gi));
        end
    endgenerate

`ifdef REG_WRITE_PORT_BYPASS_EN
    logic [AW-1:0] byp_slot  [DEPTH];
    logic [DEPTH-1:0] byp_match;

    // Slot gi is the gi-th oldest occupied entry; higher gi means younger.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_byp
            assign byp_slot[gi]  = rptr_reg + AW'(gi);
            assign byp_match[gi] = (CW'(gi) < count_reg)
                                   && (regid_mem[byp_slot[gi]] == byp_regid)
                                   && (byp_regid != 4'd0);
        end
    endgenerate

    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (byp_match[k]) begin
                byp_hit  = 1'b1;
                byp_data = data_mem[byp_slot[k]];
            end
        end
    end
`else
    logic byp_unused;
    assign byp_unused = ^byp_regid;
    assign byp_hit    = 1'b0;
    assign byp_data   = '0;
`endif

endmodule

// File: doc/reg_write_port.md
Name: reg_write_port

Overview:
- Write-side companion to the register file's 4-to-16 read decoders.
- Buffers writeback requests (register id plus 16-bit data) from the pipeline in a small FIFO with a valid/ready handshake.
- Drains one request per cycle into the register file as a one-hot 16-bit write wordline plus write data.
- Honours a register-file stall input and enforces R0 as hardwired zero.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DW, 16, data width of the write value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  writeback request valid.
- in_ready  output  1  FIFO can accept a request this cycle.
- in_regid  input  4  destination register id.
- in_data  input  DW  value to write.
- wr_stall  input  1  register file cannot take a write this cycle.
- WriteEnable  output  1  write strobe to the register file.
- WriteWordline  output  16  one-hot destination select; all zero when WriteEnable=0.
- WriteData  output  DW  data for the selected register.
- pending  output  $clog2(DEPTH)+1  number of occupied FIFO entries.
- byp_regid  input  4  bypass lookup id (used only with BYPASS_EN).
- byp_hit  output  1  a pending write targets byp_regid.
- byp_data  output  DW  data of the youngest matching pending write.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; read/write pointers and count = 0.
  - pending=0, in_ready=1, WriteEnable=0, WriteWordline=0, WriteData=0, byp_hit=0, byp_data=0.
  - Reset mid-operation discards all queued entries; no partial write is issued.
- Push: on a rising edge with in_valid && in_ready, {in_regid, in_data} is written at wptr; wptr increments modulo DEPTH.
- in_ready = (pending != DEPTH). It depends only on registered state; there is no combinational path from wr_stall or in_valid.
- Head decode is combinational from the FIFO head:
  - head_valid = (pending != 0).
  - issue = head_valid && !wr_stall.
- Pop: on a rising edge with issue, rptr increments modulo DEPTH.
- WriteEnable = issue && (head_regid != 0).
- WriteWordline[i] = WriteEnable && (head_regid == i), so it is strictly one-hot or zero.
- WriteData = head data when WriteEnable, else 0.
- R0 handling: a request to register 0 is accepted and popped, consuming one drain cycle, but never asserts WriteEnable.
- Latency: a request accepted into an empty FIFO at edge k drives WriteWordline in the cycle following edge k (if wr_stall=0). It is retired at edge k+1.
- Ordering: strict FIFO. Two writes to the same register are issued in acceptance order.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop on the same edge: unchanged.
- Full: in_ready=0 for the whole cycle, even if a pop occurs on that edge; a push is possible the following cycle.
- Empty: WriteEnable=0 regardless of wr_stall; pointers hold.
- Stall: wr_stall=1 holds the head. WriteEnable=0 and WriteWordline=0; pushes still proceed while not full.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.

Optional Feature:
- Macro: REG_WRITE_PORT_BYPASS_EN.
- Defined:
  - byp_hit=1 when any pending entry (including the head being issued this cycle) has regid == byp_regid and byp_regid != 0.
  - byp_data is the data of the youngest such entry.
  - Both outputs are combinational from FIFO contents and byp_regid.
- Undefined: byp_hit and byp_data are tied to 0 and byp_regid is ignored. The ports remain present.

Test Plan:
- Reset, then push {R5, 16'hABCD} with wr_stall=0 -> next cycle WriteEnable=1, WriteWordline=16'h0020, WriteData=16'hABCD; pending returns to 0 after that edge.
- wr_stall=1, push R1..R4 (data 1..4) -> pending=4, in_ready=0, a fifth push is refused; release stall -> wordlines 0x0002, 0x0004, 0x0008, 0x0010 on 4 consecutive cycles, in_ready=1 after the first pop.
- Push {R0, 16'hFFFF} then {R7, 16'h1234} -> cycle 1: WriteEnable=0, WriteWordline=0; cycle 2: WriteWordline=16'h0080, WriteData=16'h1234.
- Continuous push/pop for 10 requests across pointer wrap -> pending stays 1, every wordline and data value matches input order, no bubbles.
- Assert rst asynchronously (mid-clock) with 3 entries queued -> WriteEnable=0 and pending=0 immediately, not at the next edge; no queued write appears after rst deasserts.
- (BYPASS_EN) wr_stall=1, push {R3, 0x0011} then {R3, 0x0022}, byp_regid=3 -> byp_hit=1, byp_data=0x0022; byp_regid=0 -> byp_hit=0.
